// File: rtl/flow_chain_drain_ctrl.sv
`default_nettype none
// ============================================================================
// flow_chain_drain_ctrl : drains one chamber through a flow-switch chain
//   into the shared merge. Valves open merge-inward, hold, then close outward.
// Revision: 1.0
// ============================================================================
module flow_chain_drain_ctrl #(
  parameter int N_SW   = 6,
  parameter int SETTLE = 8,
  parameter int DUR_W  = 16,
  parameter int SLOT_W = $clog2(2*N_SW)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_chain,
  input  logic [SLOT_W-1:0] req_slot,
  input  logic [DUR_W-1:0]  req_dur,
  input  logic              abort,
  output logic [2*N_SW-1:0] valve_a,
  output logic [2*N_SW-1:0] valve_b,
  output logic [1:0]        merge_sel,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int SET_W = $clog2(SETTLE+1);
  localparam int IDX_W = $clog2(N_SW+1);

  localparam logic [SET_W-1:0] SET_RELOAD = SET_W'(SETTLE-1);
  localparam logic [SET_W-1:0] SET_ONE    = SET_W'(1);
  localparam logic [DUR_W-1:0] DUR_ONE    = DUR_W'(1);
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_NONE   = IDX_W'(N_SW);
  localparam logic [IDX_W-1:0] IDX_OUTER  = IDX_W'(N_SW-1);
  localparam logic [1:0]       MODE_CLOSED = 2'b00;
  localparam logic [1:0]       MODE_PASS   = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_OPEN  = 3'd1,
    ST_HOLD  = 3'd2,
    ST_CLOSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                chain_q, chain_d;
  logic                branch_q, branch_d;
  logic [IDX_W-1:0]    tgt_q, tgt_d;
  logic [DUR_W-1:0]    dur_q, dur_d;
  logic [DUR_W-1:0]    dur_cnt_q, dur_cnt_d;
  logic [SET_W-1:0]    set_cnt_q, set_cnt_d;
  logic                merge_on_q, merge_on_d;
  logic                any_open_q, any_open_d;
  logic                tgt_open_q, tgt_open_d;
  logic [IDX_W-1:0]    sw_idx_q, sw_idx_d;
  logic [IDX_W-1:0]    cls_idx_q, cls_idx_d;
  logic                fin_q, fin_d;
  logic                aborted_q, aborted_d;
  logic [2*N_SW-1:0]   valve_a_q, valve_a_d;
  logic [2*N_SW-1:0]   valve_b_q, valve_b_d;
  logic [1:0]          merge_q, merge_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [2*N_SW-1:0]   vec;
  logic [IDX_W-1:0]    nxt;
  logic                tgt_close;
  logic                go_abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      chain_q    <= 1'b0;
      branch_q   <= 1'b0;
      tgt_q      <= '0;
      dur_q      <= '0;
      dur_cnt_q  <= '0;
      set_cnt_q  <= '0;
      merge_on_q <= 1'b0;
      any_open_q <= 1'b0;
      tgt_open_q <= 1'b0;
      sw_idx_q   <= '0;
      cls_idx_q  <= '0;
      fin_q      <= 1'b0;
      aborted_q  <= 1'b0;
      valve_a_q  <= '0;
      valve_b_q  <= '0;
      merge_q    <= 2'b00;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      chain_q    <= chain_d;
      branch_q   <= branch_d;
      tgt_q      <= tgt_d;
      dur_q      <= dur_d;
      dur_cnt_q  <= dur_cnt_d;
      set_cnt_q  <= set_cnt_d;
      merge_on_q <= merge_on_d;
      any_open_q <= any_open_d;
      tgt_open_q <= tgt_open_d;
      sw_idx_q   <= sw_idx_d;
      cls_idx_q  <= cls_idx_d;
      fin_q      <= fin_d;
      aborted_q  <= aborted_d;
      valve_a_q  <= valve_a_d;
      valve_b_q  <= valve_b_d;
      merge_q    <= merge_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    chain_d    = chain_q;
    branch_d   = branch_q;
    tgt_d      = tgt_q;
    dur_d      = dur_q;
    dur_cnt_d  = dur_cnt_q;
    set_cnt_d  = set_cnt_q;
    merge_on_d = merge_on_q;
    any_open_d = any_open_q;
    tgt_open_d = tgt_open_q;
    sw_idx_d   = sw_idx_q;
    cls_idx_d  = cls_idx_q;
    fin_d      = fin_q;
    aborted_d  = aborted_q;
    valve_a_d  = valve_a_q;
    valve_b_d  = valve_b_q;
    merge_d    = merge_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    // Working copy of the active chain; only this chain is ever written back.
    vec        = chain_q ? valve_b_q : valve_a_q;
    nxt        = IDX_OUTER;
    tgt_close  = 1'b0;
    go_abort   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (int'(req_slot) >= 2*N_SW) begin
            err_d = 1'b1;
          end else begin
            state_d    = ST_OPEN;
            chain_d    = req_chain;
            tgt_d      = IDX_W'(req_slot >> 1);
            branch_d   = req_slot[0];
            dur_d      = req_dur;
            set_cnt_d  = '0;
            merge_on_d = 1'b0;
            any_open_d = 1'b0;
            tgt_open_d = 1'b0;
            fin_d      = 1'b0;
            aborted_d  = 1'b0;
          end
        end
      end

      ST_OPEN: begin
        if (abort) begin
          go_abort = 1'b1;
        end else if (set_cnt_q != '0) begin
          set_cnt_d = set_cnt_q - SET_ONE;
        end else if (tgt_open_q) begin
          if (dur_q == '0) begin
            tgt_close = 1'b1;
          end else begin
            state_d   = ST_HOLD;
            dur_cnt_d = dur_q - DUR_ONE;
          end
        end else if (!merge_on_q) begin
          merge_d    = chain_q ? 2'b10 : 2'b01;
          merge_on_d = 1'b1;
          set_cnt_d  = SET_RELOAD;
        end else begin
          nxt = any_open_q ? (sw_idx_q - IDX_ONE) : IDX_OUTER;
          vec[2*int'(nxt) +: 2] = (nxt == tgt_q) ? {1'b1, branch_q} : MODE_PASS;
          sw_idx_d   = nxt;
          any_open_d = 1'b1;
          tgt_open_d = (nxt == tgt_q);
          set_cnt_d  = SET_RELOAD;
        end
      end

      ST_HOLD: begin
        if (abort) begin
          go_abort = 1'b1;
        end else if (dur_cnt_q == '0) begin
          tgt_close = 1'b1;
        end else begin
          dur_cnt_d = dur_cnt_q - DUR_ONE;
        end
      end

      ST_CLOSE: begin
        if (abort) begin
          aborted_d = 1'b1;
        end
        if (set_cnt_q != '0) begin
          set_cnt_d = set_cnt_q - SET_ONE;
        end else if (fin_q) begin
          state_d = ST_DONE;
          if (aborted_q || abort) begin
            err_d = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end else if (cls_idx_q == IDX_NONE) begin
          merge_d   = 2'b00;
          fin_d     = 1'b1;
          set_cnt_d = SET_RELOAD;
        end else begin
          vec[2*int'(cls_idx_q) +: 2] = MODE_CLOSED;
          cls_idx_d = cls_idx_q + IDX_ONE;
          set_cnt_d = SET_RELOAD;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort starts the close-down at the innermost opened switch on the next edge.
    if (go_abort) begin
      state_d   = ST_CLOSE;
      set_cnt_d = '0;
      cls_idx_d = any_open_q ? sw_idx_q : IDX_NONE;
      aborted_d = 1'b1;
    end

    if (tgt_close) begin
      vec[2*int'(tgt_q) +: 2] = MODE_CLOSED;
      cls_idx_d = tgt_q + IDX_ONE;
      state_d   = ST_CLOSE;
      set_cnt_d = SET_RELOAD;
    end

    if (chain_q) begin
      valve_b_d = vec;
    end else begin
      valve_a_d = vec;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign valve_a   = valve_a_q;
  assign valve_b   = valve_b_q;
  assign merge_sel = merge_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_flow_chain_drain_ctrl.sv
`default_nettype none
// ============================================================================
// tb_flow_chain_drain_ctrl : directed bench for flow_chain_drain_ctrl
// Revision: 1.0
// ============================================================================
module tb_flow_chain_drain_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_chain;
  logic [3:0]  req_slot;
  logic [15:0] req_dur;
  logic        abort;
  logic [11:0] valve_a;
  logic [11:0] valve_b;
  logic [1:0]  merge_sel;
  logic        busy;
  logic        done;
  logic        err;

  int checks;
  int errors;
  int cur;

  flow_chain_drain_ctrl #(
    .N_SW   (6),
    .SETTLE (8),
    .DUR_W  (16)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_chain (req_chain),
    .req_slot  (req_slot),
    .req_dur   (req_dur),
    .abort     (abort),
    .valve_a   (valve_a),
    .valve_b   (valve_b),
    .merge_sel (merge_sel),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the k-th edge following the accept edge.
  task automatic at(input int k);
    if (k > cur) begin
      repeat (k - cur) @(posedge clk);
      #1;
      cur = k;
    end
  endtask

  task automatic accept(input logic ch, input logic [3:0] slot, input logic [15:0] dur,
                        input logic ab, input logic hold);
    req_valid = 1'b1;
    req_chain = ch;
    req_slot  = slot;
    req_dur   = dur;
    abort     = ab;
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
    abort = 1'b0;
    cur   = 0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    cur       = 0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_chain = 1'b0;
    req_slot  = 4'd0;
    req_dur   = 16'd0;
    abort     = 1'b0;

    #12;
    chk("rst_valve_a", 32'(valve_a), 32'h0);
    chk("rst_valve_b", 32'(valve_b), 32'h0);
    chk("rst_merge", 32'(merge_sel), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done_err", 32'({done, err}), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Chain A, slot 5 (switch 2, branch 1), hold 20; abort raised with the accept is ignored
    accept(1'b0, 4'd5, 16'd20, 1'b1, 1'b0);
    chk("s1_busy_T0", 32'(busy), 32'h1);
    chk("s1_ready_T0", 32'(req_ready), 32'h0);
    chk("s1_merge_T0", 32'(merge_sel), 32'h0);
    at(1);   chk("s1_merge_T1", 32'(merge_sel), 32'h1);
    at(8);   chk("s1_va_T8", 32'(valve_a), 32'h000);
    at(9);   chk("s1_va_T9", 32'(valve_a), 32'h400);
    at(17);  chk("s1_va_T17", 32'(valve_a), 32'h500);
    at(25);  chk("s1_va_T25", 32'(valve_a), 32'h540);
    at(32);  chk("s1_va_T32", 32'(valve_a), 32'h540);
    at(33);  chk("s1_va_T33", 32'(valve_a), 32'h570);
    chk("s1_vb_T33", 32'(valve_b), 32'h0);
    at(60);  chk("s1_va_T60", 32'(valve_a), 32'h570);
    at(61);  chk("s1_va_T61", 32'(valve_a), 32'h540);
    at(69);  chk("s1_va_T69", 32'(valve_a), 32'h500);
    at(77);  chk("s1_va_T77", 32'(valve_a), 32'h400);
    at(85);  chk("s1_va_T85", 32'(valve_a), 32'h000);
    at(92);  chk("s1_merge_T92", 32'(merge_sel), 32'h1);
    at(93);  chk("s1_merge_T93", 32'(merge_sel), 32'h0);
    at(100); chk("s1_done_T100", 32'(done), 32'h0);
    at(101); chk("s1_done_T101", 32'({done, err, busy}), 32'b101);
    at(102); chk("s1_idle_T102", 32'({done, busy, req_ready}), 32'b001);

    // Chain B, slot 10 (switch 5, branch 0), zero hold
    accept(1'b1, 4'd10, 16'd0, 1'b0, 1'b0);
    at(1);   chk("s2_merge_T1", 32'(merge_sel), 32'h2);
    at(9);   chk("s2_vb_T9", 32'(valve_b), 32'h800);
    chk("s2_va_T9", 32'(valve_a), 32'h0);
    at(16);  chk("s2_vb_T16", 32'(valve_b), 32'h800);
    at(17);  chk("s2_vb_T17", 32'(valve_b), 32'h000);
    at(24);  chk("s2_merge_T24", 32'(merge_sel), 32'h2);
    at(25);  chk("s2_merge_T25", 32'(merge_sel), 32'h0);
    at(33);  chk("s2_done_T33", 32'({done, err}), 32'b10);
    chk("s2_va_T33", 32'(valve_a), 32'h0);
    at(34);  chk("s2_ready_T34", 32'(req_ready), 32'h1);

    // Out-of-range slot
    accept(1'b0, 4'd12, 16'd5, 1'b0, 1'b0);
    chk("s3_err", 32'(err), 32'h1);
    chk("s3_ready", 32'(req_ready), 32'h1);
    chk("s3_busy", 32'(busy), 32'h0);
    chk("s3_valves", 32'({valve_a, valve_b, merge_sel}), 32'h0);
    at(1);   chk("s3_err_clear", 32'(err), 32'h0);

    // Abort during OPEN after switches 5 and 4 are open
    accept(1'b0, 4'd5, 16'd20, 1'b0, 1'b0);
    at(19);  abort = 1'b1;
    at(20);  abort = 1'b0;
    chk("s4_va_T20", 32'(valve_a), 32'h500);
    at(21);  chk("s4_va_T21", 32'(valve_a), 32'h400);
    at(29);  chk("s4_va_T29", 32'(valve_a), 32'h000);
    at(33);  chk("s4_va_T33", 32'(valve_a), 32'h000);
    at(36);  chk("s4_merge_T36", 32'(merge_sel), 32'h1);
    at(37);  chk("s4_merge_T37", 32'(merge_sel), 32'h0);
    at(44);  chk("s4_err_T44", 32'(err), 32'h0);
    at(45);  chk("s4_end_T45", 32'({done, err}), 32'b01);
    at(46);  chk("s4_idle_T46", 32'({err, req_ready}), 32'b01);

    // Asynchronous reset mid-sequence
    accept(1'b0, 4'd5, 16'd20, 1'b0, 1'b0);
    at(40);  chk("s5_va_T40", 32'(valve_a), 32'h570);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s5_va_async", 32'(valve_a), 32'h0);
    chk("s5_merge_async", 32'(merge_sel), 32'h0);
    chk("s5_busy_async", 32'(busy), 32'h0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    chk("s5_ready_rel", 32'({req_ready, busy}), 32'b10);
    @(posedge clk);
    #1;
    chk("s5_idle_after", 32'({valve_a, merge_sel, busy}), 32'h0);

    // req_valid held high: second request taken only in the IDLE cycle after DONE
    accept(1'b1, 4'd10, 16'd0, 1'b0, 1'b1);
    at(32);  chk("s6_ready_T32", 32'(req_ready), 32'h0);
    at(33);  chk("s6_done_T33", 32'(done), 32'h1);
    at(34);  chk("s6_idle_T34", 32'({req_ready, busy}), 32'b10);
    at(35);  chk("s6_acc2_T35", 32'({req_ready, busy}), 32'b01);
    req_valid = 1'b0;
    at(36);  chk("s6_merge_T36", 32'(merge_sel), 32'h2);
    at(68);  chk("s6_done2_T68", 32'(done), 32'h1);
    at(69);  chk("s6_idle2_T69", 32'({busy, req_ready}), 32'b01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
